// File: rtl/mpy_share_ctrl.sv
// Purpose: shares one external combinational 32x32 signed multiplier between two requesters (round-robin).
// Latency: accept edge to rsp_valid high is exactly MPY_CYCLES edges; per-op occupancy is MPY_CYCLES+2 cycles.
// Backpressure: one op in flight; requesters are stalled (ready low) until the response is taken via rsp_ready.
module mpy_share_ctrl #(
    parameter int MPY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_s,
    input  logic [31:0] req0_t,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_s,
    input  logic [31:0] req1_t,
    output logic        req1_ready,
    output logic [31:0] mpy_s,
    output logic [31:0] mpy_t,
    input  logic [31:0] mpy_y_hi,
    input  logic [31:0] mpy_y_lo,
    input  logic        mpy_n,
    input  logic        mpy_z,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_n,
    output logic        rsp_z,
    input  logic        rsp_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Loaded on grant; the hold counter counts down to zero while the
    // multiplier output settles across the multicycle path.
    localparam logic [3:0] CNT_LOAD = 4'(MPY_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rr_ptr;
    logic [3:0]  r_cnt;
    logic [31:0] r_mpy_s;
    logic [31:0] r_mpy_t;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_hi;
    logic [31:0] r_rsp_lo;
    logic        r_rsp_n;
    logic        r_rsp_z;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic [31:0] w_gnt_s;
    logic [31:0] w_gnt_t;
    logic        w_capture;

    // Next-state and grant decode; grants only exist in IDLE and never during reset.
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!reset) begin
                    // rr_ptr only matters when both request; a lone requester always wins.
                    w_grant0 = req0_valid && (!req1_valid || !r_rr_ptr);
                    w_grant1 = req1_valid && (!req0_valid ||  r_rr_ptr);
                end
                if (w_grant0 || w_grant1) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = w_grant0 || w_grant1;
    assign w_gnt_s  = w_grant1 ? req1_s : req0_s;
    assign w_gnt_t  = w_grant1 ? req1_t : req0_t;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping: operand latch, owner ID, round-robin pointer and hold counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
            r_cnt    <= 4'd0;
            r_mpy_s  <= 32'd0;
            r_mpy_t  <= 32'd0;
            r_rsp_id <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= w_grant0;
            r_cnt    <= CNT_LOAD;
            r_mpy_s  <= w_gnt_s;
            r_mpy_t  <= w_gnt_t;
            r_rsp_id <= w_grant1;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response register: product captured once the hold expires, held until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hi    <= 32'd0;
            r_rsp_lo    <= 32'd0;
            r_rsp_n     <= 1'b0;
            r_rsp_z     <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hi    <= mpy_y_hi;
            r_rsp_lo    <= mpy_y_lo;
            r_rsp_n     <= mpy_n;
            r_rsp_z     <= mpy_z;
        end else if (r_state == S_DONE && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign mpy_s      = r_mpy_s;
    assign mpy_t      = r_mpy_t;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_hi     = r_rsp_hi;
    assign rsp_lo     = r_rsp_lo;
    assign rsp_n      = r_rsp_n;
    assign rsp_z      = r_rsp_z;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mpy_share_ctrl.sv
// Bench for mpy_share_ctrl: two instances (MPY_CYCLES = 2 and 4), each with its own
// multiplier model, stimulus and transaction-level reference/scoreboard.
module tb_mpy_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] s;
        logic [31:0] t;
    } op_t;

    task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL inst%0d %s @%0t: got %0h expected %0h", g, nm, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int MC = (g == 0) ? 2 : 4;

        logic        reset, r0v, r1v, r0rdy, r1rdy, rspv, rspid, rspn, rspz, rsprdy, busy, mn, mz;
        logic [31:0] r0s, r0t, r1s, r1t, ms, mt, yhi, ylo, rhi, rlo;
        logic signed [63:0] prod;
        bit fin = 1'b0;

        // External combinational multiplier.
        assign prod       = $signed(ms) * $signed(mt);
        assign {yhi, ylo} = prod;
        assign mn         = prod[63];
        assign mz         = (prod == 64'sd0);

        mpy_share_ctrl #(.MPY_CYCLES(MC)) dut (
            .clk(clk), .reset(reset),
            .req0_valid(r0v), .req0_s(r0s), .req0_t(r0t), .req0_ready(r0rdy),
            .req1_valid(r1v), .req1_s(r1s), .req1_t(r1t), .req1_ready(r1rdy),
            .mpy_s(ms), .mpy_t(mt), .mpy_y_hi(yhi), .mpy_y_lo(ylo), .mpy_n(mn), .mpy_z(mz),
            .rsp_valid(rspv), .rsp_id(rspid), .rsp_hi(rhi), .rsp_lo(rlo),
            .rsp_n(rspn), .rsp_z(rspz), .rsp_ready(rsprdy), .busy(busy)
        );

        // Reference model: one op in flight, free again the cycle after its response is taken.
        op_t q[$];
        int  cyc = 0;
        int  acc_cyc = 0;
        bit  free = 1'b1;
        bit  rr = 1'b0;
        bit  prst = 1'b0;

        always @(negedge clk) begin
            logic   e0, e1, exp_v, hs;
            longint p;
            cyc++;
            hs = 1'b0;
            if (prst) begin
                chk(g, "rst_mpy",   {ms, mt}, 64'd0);
                chk(g, "rst_rsp",   {rhi, rlo}, 64'd0);
                chk(g, "rst_flags", 64'({busy, rspv, rspid, rspn, rspz}), 64'd0);
            end
            if (reset) begin
                chk(g, "ready_in_reset", 64'({r0rdy, r1rdy}), 64'd0);
                q.delete();
                free = 1'b1;
                rr   = 1'b0;
            end else begin
                e0 = free && r0v && (!r1v || !rr);
                e1 = free && r1v && (!r0v || rr);
                chk(g, "ready", 64'({r0rdy, r1rdy}), 64'({e0, e1}));
                chk(g, "busy", 64'(busy), 64'(!free));
                exp_v = (q.size() > 0) && (cyc - acc_cyc > MC);
                chk(g, "rsp_valid", 64'(rspv), 64'(exp_v));
                if (q.size() > 0) begin
                    chk(g, "mpy_operands", {ms, mt}, {q[0].s, q[0].t});
                    if (rspv && exp_v) begin
                        p = longint'($signed(q[0].s)) * longint'($signed(q[0].t));
                        chk(g, "rsp_product", {rhi, rlo}, 64'(p));
                        chk(g, "rsp_id_flags", 64'({rspid, rspn, rspz}),
                            64'({q[0].id, p < 0, p == 0}));
                        if (rsprdy) begin
                            void'(q.pop_front());
                            hs = 1'b1;
                        end
                    end
                end
                if (e0 || e1) begin
                    q.push_back(e1 ? op_t'{1'b1, r1s, r1t} : op_t'{1'b0, r0s, r0t});
                    acc_cyc = cyc;
                    free    = 1'b0;
                    rr      = e0;
                end
                if (hs) free = 1'b1;
            end
            prst = reset;
        end

        // Stimulus: inputs change 1 time unit after the rising edge.
        initial begin
            // Reset with req0 pending; that request (3 * -2) is the first IDLE grant.
            reset = 1'b1; r0v = 1'b1; r0s = 32'd3; r0t = 32'hFFFF_FFFE;
            r1v = 1'b0; r1s = 32'd0; r1t = 32'd0; rsprdy = 1'b1;
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            @(posedge clk);
            #1 r0v = 1'b0;
            repeat (MC + 4) @(posedge clk);

            // Idle reset returns rr_ptr to 0, then continuous contention: grants 0,1,0,1.
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            r0v = 1'b1; r0s = 32'd7; r0t = 32'd6;
            r1v = 1'b1; r1s = 32'd0; r1t = 32'd5;
            repeat (4 * (MC + 2)) @(posedge clk);
            #1 r0v = 1'b0; r1v = 1'b0;
            repeat (2) @(posedge clk);

            // Backpressure in DONE with req1 waiting; operands churn every cycle.
            #1 r0v = 1'b1; r0s = 32'hFFFF_FFF0; r0t = 32'h0001_0003; rsprdy = 1'b0;
            for (int i = 0; i < MC + 6; i++) begin
                @(posedge clk);
                #1 r0v = 1'b0; r1v = 1'b1;
                r0s = $urandom; r0t = $urandom; r1s = $urandom; r1t = $urandom;
            end
            rsprdy = 1'b1;
            repeat (MC + 4) @(posedge clk);
            #1 r1v = 1'b0;
            repeat (MC + 3) @(posedge clk);

            // Reset while in WAIT: op discarded, req0 wins the first contended grant.
            #1 r0v = 1'b1; r0s = 32'd9; r0t = 32'd9;
            @(posedge clk);
            #1 r0v = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0; r0v = 1'b1; r1v = 1'b1; r1s = 32'd11; r1t = 32'hFFFF_FFFF;
            repeat (2 * (MC + 2)) @(posedge clk);
            #1 r0v = 1'b0; r1v = 1'b0;

            // Random traffic, backpressure and occasional resets.
            for (int i = 0; i < 700; i++) begin
                @(posedge clk);
                #1;
                r0v    = 1'($urandom_range(1, 0));
                r1v    = 1'($urandom_range(1, 0));
                r0s    = ($urandom_range(7, 0) == 0) ? 32'd0 : $urandom;
                r0t    = ($urandom_range(7, 0) == 0) ? 32'd0 : $urandom;
                r1s    = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(20, 0)) : $urandom;
                r1t    = $urandom;
                rsprdy = ($urandom_range(3, 0) != 0);
                reset  = ($urandom_range(149, 0) == 0);
            end

            // Drain.
            @(posedge clk);
            #1 r0v = 1'b0; r1v = 1'b0; rsprdy = 1'b1; reset = 1'b0;
            repeat (MC + 6) @(posedge clk);
            #2 chk(g, "drained", 64'(q.size()), 64'd0);
            fin = 1'b1;
        end
    end

    initial begin
        fork
            wait (inst[0].fin && inst[1].fin);
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected completion");
                fails++;
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mpy_share_ctrl.md
Name: mpy_share_ctrl

Overview:
- Shares one combinational 32x32 signed multiplier (MPY_32-style: S, T in; Y_hi, Y_lo, N, Z out) between two requesters, e.g. the integer pipeline and a coprocessor/debug port.
- Round-robin arbitration with valid/ready handshakes.
- Operands are held stable in registers for a programmable number of cycles, so the multiplier can be a multicycle path.
- The 64-bit product and N/Z flags are registered and returned with the requester ID; the C and V flags are not used.

Parameters:
- MPY_CYCLES, 2, cycles operands are held before the product is captured. Legal range is 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_s  in  32  requester 0 operand S
- req0_t  in  32  requester 0 operand T
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid  in  1  requester 1 has an operation
- req1_s  in  32  requester 1 operand S
- req1_t  in  32  requester 1 operand T
- req1_ready  out  1  requester 1 accepted this cycle
- mpy_s  out  32  operand S to the multiplier (registered)
- mpy_t  out  32  operand T to the multiplier (registered)
- mpy_y_hi  in  32  multiplier product [63:32]
- mpy_y_lo  in  32  multiplier product [31:0]
- mpy_n  in  1  multiplier N flag
- mpy_z  in  1  multiplier Z flag
- rsp_valid  out  1  response available
- rsp_id  out  1  requester that owns the response
- rsp_hi  out  32  product high word
- rsp_lo  out  32  product low word
- rsp_n  out  1  captured N flag
- rsp_z  out  1  captured Z flag
- rsp_ready  in  1  consumer takes the response
- busy  out  1  state is not IDLE

Behaviour:
- All state changes on the rising edge of clk. Reset is synchronous and has priority over everything else.
- Reset values:
  - state = IDLE; rr_ptr = 0 (requester 0 favoured); cnt = 0
  - mpy_s = 0; mpy_t = 0
  - rsp_valid = 0; rsp_id = 0; rsp_hi = 0; rsp_lo = 0; rsp_n = 0; rsp_z = 0
  - busy = 0
- State IDLE:
  - reqX_ready is combinational: asserted only in IDLE, and only for the granted requester.
  - Grant rules:
    - Only one valid: grant it.
    - Both valid: grant the requester selected by rr_ptr.
    - Neither valid: stay in IDLE.
  - On grant edge:
    - mpy_s/mpy_t <= granted operands
    - rsp_id <= granted ID
    - rr_ptr <= the other ID
    - cnt <= MPY_CYCLES-1
    - state <= WAIT
  - At most one ready is high per cycle.
- State WAIT:
  - Both readys are low; mpy_s/mpy_t are held constant.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: rsp_hi/lo/n/z <= mpy inputs; rsp_valid <= 1; state <= DONE.
  - Latency from the accept edge to rsp_valid high is exactly MPY_CYCLES edges.
- State DONE:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0 (backpressure of any length).
  - On rsp_ready=1: rsp_valid <= 0; state <= IDLE.
  - The next grant can occur no earlier than the cycle after the return to IDLE.
  - Per-op occupancy is MPY_CYCLES+2 cycles, with zero backpressure.
- rsp_valid does not depend combinationally on rsp_ready.
- rsp_ready while in IDLE or WAIT is ignored.
- A requester dropping valid while not granted has no effect; nothing is queued.
- Arithmetic is fully performed by the external multiplier; this block does no width conversion and passes N/Z as captured.
- Reset mid-operation (in WAIT or DONE):
  - The operation is discarded; no response is ever produced for it.
  - Outputs take their reset values on the next edge.
  - The round-robin pointer returns to 0.
- busy = (state != IDLE), registered-equivalent (decoded from the state register).

Test Plan:
- Reset then idle: hold reset 2 cycles with req0_valid=1 → readys low during reset; after release, all outputs are 0; req0_ready=1 in the first IDLE cycle.
- Single op latency (MPY_CYCLES=2): req0 S=0x00000003, T=0xFFFFFFFE (-2); multiplier model returns -6 → rsp_valid rises exactly 2 edges after the accept, with rsp_hi=0xFFFFFFFF, rsp_lo=0xFFFFFFFA, rsp_n=1, rsp_z=0, rsp_id=0.
- Contention: both valid continuously, req0 (7,6), req1 (0,5) → grants alternate 0,1,0,1. Responses: id0 lo=42 z=0; id1 hi=lo=0 z=1. Exactly one ready per grant.
- Backpressure: rsp_ready low for 5 cycles in DONE → rsp_* stable, busy=1, no ready asserted; rsp_ready=1 → rsp_valid falls next edge; next grant follows one cycle later.
- Operand stability: change req0_s/req0_t every cycle after the grant (MPY_CYCLES=4) → mpy_s/mpy_t constant through all 4 WAIT cycles; captured product matches the granted operands.
- Reset mid-op: assert reset in WAIT → no rsp_valid pulse; rr_ptr=0. With both requesters valid after release, req0 is granted first.
